// File: rtl/id_hazard_ctrl_if.sv
// id_hazard_ctrl_if: ID-stage hazard/branch bus; ID_HAZARD_STATS_EN adds stats_clr, stall_cnt and flush_cnt
interface id_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
`ifdef ID_HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  id_branch;
  logic                  id_bne;
  logic                  id_jump;
  logic                  id_jr;
  logic                  cmp_eq;
  logic [1:0]            forbranchA;
  logic [1:0]            forbranchB;
  logic [1:0]            PCsrc;
  logic                  stall;
  logic                  id_bubble;
  logic                  flush_ifid;
`ifdef ID_HAZARD_STATS_EN
  logic                  stats_clr;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
`endif
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_regwrite,
           id_memread, id_branch, id_bne, id_jump, id_jr, cmp_eq,
`ifdef ID_HAZARD_STATS_EN
    output stats_clr,
    input  stall_cnt, flush_cnt,
`endif
    input  forbranchA, forbranchB, PCsrc, stall, id_bubble, flush_ifid
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_regwrite,
           id_memread, id_branch, id_bne, id_jump, id_jr, cmp_eq,
`ifdef ID_HAZARD_STATS_EN
    input  stats_clr,
    output stall_cnt, flush_cnt,
`endif
    output forbranchA, forbranchB, PCsrc, stall, id_bubble, flush_ifid
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage stall/forward/PC-select from an EX/MEM/WB dest shadow; ID_HAZARD_STATS_EN adds saturating stall/flush counters
module id_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
`ifdef ID_HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic            clk,
  input logic            rst_n,
  id_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic                  v;
    logic                  rw;
    logic                  ld;
    logic [REG_ADDR_W-1:0] d;
  } slot_t;
  slot_t r_ex, r_mem, r_wb, w_id;
  logic w_act, w_br, w_stall, w_go, w_flush;
  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;
  logic [1:0] w_fa, w_fb, w_pc;
  function automatic logic hit(slot_t s, logic [REG_ADDR_W-1:0] a, logic u);
    return s.v && s.rw && (s.d != '0) && (s.d == a) && u;
  endfunction
  // outputs are forced to 0 while reset is held, not just once the shadow clears
  assign w_act    = bus.id_valid & rst_n;
  assign w_br     = bus.id_branch | bus.id_jr;
  assign w_ex_rs  = hit(r_ex,  bus.id_rs, bus.id_uses_rs);
  assign w_ex_rt  = hit(r_ex,  bus.id_rt, bus.id_uses_rt);
  assign w_mem_rs = hit(r_mem, bus.id_rs, bus.id_uses_rs);
  assign w_mem_rt = hit(r_mem, bus.id_rt, bus.id_uses_rt);
  assign w_wb_rs  = hit(r_wb,  bus.id_rs, bus.id_uses_rs);
  assign w_wb_rt  = hit(r_wb,  bus.id_rt, bus.id_uses_rt);
  assign w_stall  = w_act & (((r_ex.ld | w_br) & (w_ex_rs | w_ex_rt)) |
                             (w_br & r_mem.ld & (w_mem_rs | w_mem_rt)));
  assign w_go     = w_act & ~w_stall;
  always_comb begin
    w_fa = !(w_act && w_br) ? 2'b00 : (w_mem_rs && !r_mem.ld) ? 2'b01 : w_wb_rs ? 2'b10 : 2'b00;
    w_fb = !(w_act && w_br) ? 2'b00 : (w_mem_rt && !r_mem.ld) ? 2'b01 : w_wb_rt ? 2'b10 : 2'b00;
    w_pc = !w_go ? 2'b00 : bus.id_jump ? 2'b10 : bus.id_jr ? 2'b11 :
           (bus.id_branch && (bus.cmp_eq ^ bus.id_bne)) ? 2'b01 : 2'b00;
  end
  assign w_flush = w_pc != 2'b00;
  assign w_id    = '{v: bus.id_valid & ~w_stall, rw: bus.id_regwrite, ld: bus.id_memread, d: bus.id_dest};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_id;
    end
  end
  assign bus.stall      = w_stall;
  assign bus.id_bubble  = w_stall;
  assign bus.forbranchA = w_fa;
  assign bus.forbranchB = w_fb;
  assign bus.PCsrc      = w_pc;
  assign bus.flush_ifid = w_flush;
`ifdef ID_HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= bus.stats_clr ? '0 : (w_stall && !(&r_stall_cnt)) ? r_stall_cnt + 1'b1 : r_stall_cnt;
      r_flush_cnt <= bus.stats_clr ? '0 : (w_flush && !(&r_flush_cnt)) ? r_flush_cnt + 1'b1 : r_flush_cnt;
    end
  end
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif
endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Hazard and branch-sequencing controller for the ID stage of the 5-stage MIPS pipeline.
- Keeps its own shadow of the destination registers in flight in EX, MEM and WB.
- From that shadow it drives the ID stage's forbranchA/forbranchB selects and PCsrc, and it generates stall, bubble and IF/ID flush.
- Sits beside ID and consumes the instruction fields decoded there, plus cmp_eq.

Parameters:
- REG_ADDR_W, 5: register address width.
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  source register addresses.
- id_uses_rs, id_uses_rt  in  1  the instruction reads rs / rt.
- id_dest  in  REG_ADDR_W  destination register (rd or rt, already selected).
- id_regwrite  in  1  the instruction writes id_dest.
- id_memread  in  1  the instruction is a load.
- id_branch  in  1  beq/bne.
- id_bne  in  1  the branch is bne.
- id_jump  in  1  j/jal.
- id_jr  in  1  jr.
- cmp_eq  in  1  equality result from the ID comparator.
- forbranchA, forbranchB  out  2  comparator operand select: 00 = register file, 01 = exOut (EX/MEM), 10 = writeData (MEM/WB).
- PCsrc  out  2  next-PC select: 00 = pc+4, 01 = branch target, 10 = jump target, 11 = Rsdata.
- stall  out  1  hold PC and IF/ID.
- id_bubble  out  1  force a NOP into ID/EX.
- flush_ifid  out  1  zero IF/ID on the next edge.

Behaviour:
- Reset (asynchronous): all shadow slots (EX, MEM, WB) are invalid. Every output reads 0.
- Shadow advance, on each rising edge:
  - WB takes MEM, and MEM takes EX.
  - EX takes the ID fields when id_valid && !stall; otherwise EX takes an invalid slot (bubble).
  - A slot with dest = 0 or regwrite = 0 never matches anything.
- Terminology:
  - "Branch-type" means id_branch or id_jr.
  - "Match" means: the slot is valid, regwrite = 1, dest != 0, dest equals the source register, and the instruction reads that source.
- stall (combinational) is 1 when id_valid and any of the following holds:
  - (a) The EX slot is a load matching rs or rt.
  - (b) The instruction is branch-type and the EX slot matches rs or rt. For a load in EX this gives 2 stall cycles in total.
  - (c) The instruction is branch-type and the MEM slot is a load matching rs or rt.
- id_bubble equals stall.
- Forwarding, computed for branch-type instructions only; otherwise forbranchA/B = 00:
  - A non-load MEM match gives 01.
  - Otherwise a WB match gives 10.
  - Otherwise 00.
  - MEM takes priority over WB.
  - forbranchA covers rs and forbranchB covers rt.
- PCsrc and flush_ifid, when stall = 0:
  - PCsrc = 10 and flush_ifid = 1 when id_jump.
  - PCsrc = 11 and flush_ifid = 1 when id_jr.
  - PCsrc = 01 and flush_ifid = 1 when id_branch && (cmp_eq XOR id_bne).
  - Otherwise PCsrc = 00 and flush_ifid = 0.
- While stall = 1: PCsrc = 00 and flush_ifid = 0. The branch resolves in the first non-stalled cycle.
- id_valid = 0 means all outputs are 0 and no bubble is counted.
- Reset asserted mid-stall drops all shadow state immediately. There is no stall on the first cycle after release.
- Latency: all outputs are combinational from the inputs and current shadow state. Shadow state updates one cycle later.

Optional Feature:
- Macro: ID_HAZARD_STATS_EN.
- When defined:
  - Adds outputs stall_cnt and flush_cnt (CNT_W each) and input stats_clr.
  - Each counter increments on every clock with stall = 1 or flush_ifid = 1 respectively, and saturates at all-ones.
  - stats_clr synchronously zeroes both counters; clear wins over increment.
  - rst_n zeroes both counters.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Load-use (non-branch):
  - Stimulus: lw writing $8, then add reading $8.
  - Required: stall = id_bubble = 1 for exactly 1 cycle; forbranchA/B stay 00.
  - Next cycle: stall = 0.
- ALU then branch:
  - Stimulus: add $9, then beq $9,$0 with cmp_eq = 1.
  - Cycle 1: stall = 1.
  - Cycle 2: forbranchA = 01, PCsrc = 01, flush_ifid = 1.
- Load then branch:
  - Stimulus: lw $10, then bne $10,$3 with cmp_eq = 0.
  - Required: 2 stall cycles.
  - Then forbranchA = 10, PCsrc = 01, flush_ifid = 1.
- Priority and register zero:
  - MEM and WB both write $4 and beq reads $4: forbranchA = 01.
  - A load writing $0 followed by a use of $0: no stall, selects 00.
- Jump and jr:
  - j: PCsrc = 10 and flush_ifid = 1 in the same cycle, no stall.
  - jr $31 directly after addi $31: 1 stall, then PCsrc = 11.
- Reset and stats:
  - Assert rst_n = 0 during the second stall cycle of the load-branch case.
  - Required: outputs go to 0 at once, and after release there is no stall.
  - With ID_HAZARD_STATS_EN: run 3 stalls and 2 flushes, then check stall_cnt = 3 and flush_cnt = 2; stats_clr returns both to 0.
